input_conditioner: RTL and testbench

Multi-channel front end for the slide switches and push buttons that drive the board's combinational logic stages. Each channel is synchronised to the system clock, debounced by a saturating stability counter, and edge-detected. The debounced levels feed the downstream gate logic directly on inputs a/b/c/d, so those inputs are glitch-free and metastability-safe. The edge pulses are available for future counter/FSM stages.

---
 rtl/input_conditioner_pkg.sv | 34 +++
 rtl/input_conditioner_debounce_channel.sv | 100 ++++++++++
 rtl/input_conditioner.sv | 43 ++++
 tb/tb_input_conditioner.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg
//   Shared constants and types for the switch/button input conditioner.
//   The debounce window is derived from the board clock and the desired
//   settle time, so retargeting the board only means editing this file.
//
//   Contents:
//     CLK_FREQ_HZ       system clock frequency in Hz
//     DEBOUNCE_MS       time a level must stay stable before it is accepted
//     DEBOUNCE_CNT_MAX  stable cycles corresponding to DEBOUNCE_MS
//     debAction_e       per-edge decision taken by a debounce channel
//     cntWidth()        counter width needed to hold 0..cntMax-1 (min 1 bit)
package input_conditioner_pkg;

  localparam int CLK_FREQ_HZ      = 100_000_000;
  localparam int DEBOUNCE_MS      = 10;
  localparam int DEBOUNCE_CNT_MAX = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;

  // What a channel does with its stability counter at the coming edge.
  typedef enum logic [1:0] {
    ACT_CLEAR  = 2'd0,
    ACT_COUNT  = 2'd1,
    ACT_ACCEPT = 2'd2
  } debAction_e;

  // $clog2(cntMax) bits are enough to hold the largest count, cntMax-1.
  // A window of one cycle still needs a 1-bit counter to stay legal.
  function automatic int cntWidth(input int cntMax);
    if (cntMax > 1) begin
      return $clog2(cntMax);
    end
    return 1;
  endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// debounce_channel
//   One bit of the input conditioner: a synchroniser chain, a saturating
//   stability counter and registered rise/fall pulse outputs.
//
//   Ports:
//     clk      system clock, rising edge
//     rst_n    asynchronous active-low reset
//     raw_i    unsynchronised switch/button level
//     clean_o  debounced level
//     rise_o   one-cycle pulse in the first cycle clean_o reads 1
//     fall_o   one-cycle pulse in the first cycle clean_o reads 0
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_MAX     = DEBOUNCE_CNT_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CntW = cntWidth(CNT_MAX);
  localparam logic [CntW-1:0] CntLast = CntW'(CNT_MAX - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [SYNC_STAGES-1:0] syncQ, syncD;
  logic [CntW-1:0]        cntQ, cntD;
  logic                   stableQ, stableD;
  logic                   riseQ, riseD;
  logic                   fallQ, fallD;
  logic                   syncBit;
  debAction_e             action;

  // Synchroniser chain: a plain shift register, stage 0 takes the raw pin.
  assign syncD   = {syncQ[SYNC_STAGES-2:0], raw_i};
  assign syncBit = syncQ[SYNC_STAGES-1];

  // Decide what happens at the next edge. Any cycle where the synchronised
  // input agrees with the accepted level throws away a partial count, so a
  // bounce can never accumulate across separate disturbances.
  always_comb begin
    action = ACT_CLEAR;
    if (syncBit != stableQ) begin
      if (cntQ == CntLast) begin
        action = ACT_ACCEPT;
      end else begin
        action = ACT_COUNT;
      end
    end
  end

  // Next-state values for counter, accepted level and pulse registers.
  // Pulses default low so they last exactly the one acceptance cycle.
  always_comb begin
    cntD    = cntQ;
    stableD = stableQ;
    riseD   = 1'b0;
    fallD   = 1'b0;
    unique case (action)
      ACT_CLEAR: begin
        cntD = '0;
      end
      ACT_COUNT: begin
        cntD = cntQ + CntOne;
      end
      ACT_ACCEPT: begin
        cntD    = '0;
        stableD = syncBit;
        riseD   = syncBit;
        fallD   = ~syncBit;
      end
    endcase
  end

  // State registers; reset returns the channel to "accepted low, idle".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncQ   <= '0;
      cntQ    <= '0;
      stableQ <= 1'b0;
      riseQ   <= 1'b0;
      fallQ   <= 1'b0;
    end else begin
      syncQ   <= syncD;
      cntQ    <= cntD;
      stableQ <= stableD;
      riseQ   <= riseD;
      fallQ   <= fallD;
    end
  end

  assign clean_o = stableQ;
  assign rise_o  = riseQ;
  assign fall_o  = fallQ;

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner
//   Multi-channel front end for slide switches and push buttons. Each bit is
//   synchronised, debounced and edge-detected independently. clean_out bits
//   0..3 drive gate inputs a..d; the pulses feed later counter/FSM stages.
//
//   Ports:
//     clk         system clock, rising edge
//     rst_n       asynchronous active-low reset
//     raw_in      [WIDTH-1:0] unsynchronised levels
//     clean_out   [WIDTH-1:0] debounced levels
//     rise_pulse  [WIDTH-1:0] one-cycle pulse on clean_out 0->1
//     fall_pulse  [WIDTH-1:0] one-cycle pulse on clean_out 1->0
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_MAX     = DEBOUNCE_CNT_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  // One self-contained channel per input bit; no state is shared.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : gChan
    debounce_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_MAX    (CNT_MAX)
    ) uChan (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (raw_in[gi]),
      .clean_o(clean_out[gi]),
      .rise_o (rise_pulse[gi]),
      .fall_o (fall_pulse[gi])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner
//   Directed and randomised stimulus for input_conditioner with WIDTH=4,
//   SYNC_STAGES=2, CNT_MAX=4. The reference model keeps the history of raw
//   samples since reset and accepts a new level when the last CNT_MAX
//   synchronised samples (all after the previous acceptance) disagree with
//   the accepted level.
module tb_input_conditioner;

  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int CMAX = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] raw_in;
  logic [W-1:0] clean_out;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;

  int checks;
  int errors;

  // Reference model state.
  logic [W-1:0] rawHist[$];
  int           edgeN;
  int           lastAcc[W];
  logic [W-1:0] expClean;
  logic [W-1:0] expRise;
  logic [W-1:0] expFall;

  input_conditioner #(
    .WIDTH      (W),
    .SYNC_STAGES(SYNC),
    .CNT_MAX    (CMAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_in    (raw_in),
    .clean_out (clean_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value the debounce logic compares at edge m (edges numbered from 1
  // after reset release): the raw sample taken SYNC edges earlier, or the
  // reset value of the chain before that.
  function automatic logic syncAt(input int m, input int ch);
    if (m > SYNC) begin
      return rawHist[m - SYNC - 1][ch];
    end
    return 1'b0;
  endfunction

  task automatic modelReset();
    rawHist.delete();
    edgeN    = 0;
    expClean = '0;
    expRise  = '0;
    expFall  = '0;
    for (int c = 0; c < W; c++) lastAcc[c] = 0;
  endtask

  task automatic modelEdge(input logic [W-1:0] rawVal);
    logic ok;
    edgeN++;
    rawHist.push_back(rawVal);
    expRise = '0;
    expFall = '0;
    for (int c = 0; c < W; c++) begin
      ok = 1'b1;
      for (int j = 0; j < CMAX; j++) begin
        if ((edgeN - j) <= lastAcc[c]) ok = 1'b0;
        else if (syncAt(edgeN - j, c) == expClean[c]) ok = 1'b0;
      end
      if (ok) begin
        expClean[c] = ~expClean[c];
        expRise[c]  = expClean[c];
        expFall[c]  = ~expClean[c];
        lastAcc[c]  = edgeN;
      end
    end
  endtask

  task automatic checkValue(input string tag, input logic [W-1:0] observed,
                            input logic [W-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".clean"}, clean_out, expClean);
    checkValue({tag, ".rise"}, rise_pulse, expRise);
    checkValue({tag, ".fall"}, fall_pulse, expFall);
    checkValue({tag, ".excl"}, rise_pulse & fall_pulse, 4'b0000);
  endtask

  // One clock of stimulus: drive on the falling edge, advance the model on
  // the rising edge, sample 1 time unit later.
  task automatic applyStimulus(input logic [W-1:0] rawVal, input string tag);
    @(negedge clk);
    raw_in = rawVal;
    @(posedge clk);
    modelEdge(rawVal);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [W-1:0] rnd;
    logic [W-1:0] flip;
    int           riseCnt;
    int           cleanHigh;
    int           b;

    checks = 0;
    errors = 0;
    modelReset();

    // Reset held with inputs high: everything stays low.
    rst_n  = 1'b0;
    raw_in = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkValue("rst.clean", clean_out, 4'b0000);
      checkValue("rst.rise", rise_pulse, 4'b0000);
      checkValue("rst.fall", fall_pulse, 4'b0000);
    end
    $display("[TB] releasing reset");
    rst_n = 1'b1;

    // Post-reset acceptance of the held-high inputs.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(4'b1111, "postrst");
      if (i == 6) begin
        checkValue("postrst.clean6", clean_out, 4'b1111);
        checkValue("postrst.rise6", rise_pulse, 4'b1111);
      end
      if (i == 7) checkValue("postrst.rise7", rise_pulse, 4'b0000);
    end

    // Drop everything, then a clean step on bit 0.
    for (int i = 0; i < 8; i++) applyStimulus(4'b0000, "fallall");
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(4'b0001, "step0");
      if (i == 5) checkValue("step0.clean5", clean_out, 4'b0000);
      if (i == 6) begin
        checkValue("step0.clean6", clean_out, 4'b0001);
        checkValue("step0.rise6", rise_pulse, 4'b0001);
      end
      if (i == 7) checkValue("step0.rise7", rise_pulse, 4'b0000);
    end

    // Bounce on bit 1, then a steady high.
    riseCnt = 0;
    applyStimulus(4'b0011, "bounce");
    applyStimulus(4'b0001, "bounce");
    applyStimulus(4'b0011, "bounce");
    applyStimulus(4'b0001, "bounce");
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(4'b0011, "bounce");
      riseCnt += int'(rise_pulse[1]);
      if (i == 5) checkValue("bounce.clean5", clean_out, 4'b0001);
      if (i == 6) begin
        checkValue("bounce.clean6", clean_out, 4'b0011);
        checkValue("bounce.rise6", rise_pulse, 4'b0010);
      end
    end
    checks++;
    assert (riseCnt === 1) else begin
      errors++;
      $error("[TB] FAIL bounce.risecount observed=%0d expected=1", riseCnt);
    end

    // Short glitch on bit 2 must never be accepted.
    cleanHigh = 0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus((i < 3) ? 4'b0111 : 4'b0011, "glitch");
      cleanHigh += int'(clean_out[2]);
    end
    checks++;
    assert (cleanHigh === 0) else begin
      errors++;
      $error("[TB] FAIL glitch.clean2 observed=%0d expected=0", cleanHigh);
    end

    // Independent channels changing together in both directions.
    for (int i = 0; i < 8; i++) applyStimulus(4'b1010, "indep.a");
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(4'b0101, "indep.b");
      if (i == 6) begin
        checkValue("indep.clean6", clean_out, 4'b0101);
        checkValue("indep.rise6", rise_pulse, 4'b0101);
        checkValue("indep.fall6", fall_pulse, 4'b1010);
      end
    end

    // Randomised activity: occasional single-bit flips, some of them short.
    rnd = 4'b0101;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        flip    = '0;
        b       = int'($urandom_range(0, W - 1));
        flip[b] = 1'b1;
        rnd     = rnd ^ flip;
      end
      applyStimulus(rnd, "random");
    end

    // Async reset in the middle of a falling count.
    for (int i = 0; i < 8; i++) applyStimulus(4'b1111, "midrst.hi");
    for (int i = 0; i < 4; i++) applyStimulus(4'b0000, "midrst.cnt");
    #2;
    rst_n  = 1'b0;
    raw_in = 4'b1111;
    #1;
    checkValue("midrst.clean", clean_out, 4'b0000);
    checkValue("midrst.rise", rise_pulse, 4'b0000);
    checkValue("midrst.fall", fall_pulse, 4'b0000);
    modelReset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checkValue("midrst.hold", clean_out, 4'b0000);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(4'b1111, "reaccept");
      if (i == 6) checkValue("reaccept.rise6", rise_pulse, 4'b1111);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
